dms_lpf1p_trimcal: RTL
======================

// Module: dms_lpf1p_trimcal
// PURPOSE
//  Closed-loop calibration controller that drives poleTrim/gainTrim into the dms 1-pole LPF model.
//  Gain is trimmed by successive approximation (SAR) on settled DC output; pole by SAR on step response at fixed time.
//  Observes the filter only through the 1-bit comparator result cmp_hi; reference selected via ref_sel.
// PARAMETERS
//  NBIT        4      trim code width (matches filter poleTrim/gainTrim)
//  SETTLE_CYC  64     clk cycles stim_en held high before gain compare
//  MEAS_CYC    16     clk cycles after step edge before pole compare (~1 tau at target Fp)
//  DISCH_CYC   64     clk cycles stim_en held low before each pole trial
//  GAIN_DEF    4'd8   gainTrim after reset
//  POLE_DEF    4'd8   poleTrim after reset
// PORTS
//  clk       in   1     clock; all outputs registered on rising edge
//  rst       in   1     async active-high reset
//  start     in   1     1-cycle request; ignored while busy
//  abort     in   1     sync abort; return to IDLE
//  cmp_hi    in   1     1 = filter OUT above selected reference (sync to clk)
//  poleTrim  out  NBIT  pole code to filter
//  gainTrim  out  NBIT  gain code to filter
//  stim_en   out  1     1 = drive filter IN with cal step level, 0 = discharge level
//  ref_sel   out  1     0 = gain target reference, 1 = 63% step reference
//  busy      out  1     high from cycle after accepted start until done/abort
//  done      out  1     1-cycle pulse on completion
//  cal_ok    out  1     level; high after successful cal, cleared on start/abort/rst
//  cal_sat   out  2     [0] gain code ended at 0 or max, [1] pole likewise; valid with cal_ok
// BEHAVIOUR
//  Reset: poleTrim=POLE_DEF, gainTrim=GAIN_DEF, stim_en=0, ref_sel=0, busy=done=cal_ok=0, cal_sat=0, state IDLE; saved codes = defaults.
//  States: IDLE > G_SET > G_SETTLE > G_CMP (x NBIT bits, MSB first) > P_DISCH > P_SET > P_STEP > P_CMP (x NBIT) > DONE > IDLE.
//  start in IDLE: latch current codes as saved codes, gainTrim=0, bit index=NBIT-1, ref_sel=0, busy=1.
//  G_SET 1 cyc: set trial bit in gainTrim, stim_en=1. G_SETTLE SETTLE_CYC cyc. G_CMP 1 cyc: cmp_hi=1 clears trial bit else keeps.
//  Entering pole phase: poleTrim=0, ref_sel=1. P_DISCH: stim_en=0 DISCH_CYC cyc. P_SET 1 cyc: set trial bit, stim_en=1.
//  P_STEP MEAS_CYC cyc. P_CMP 1 cyc: cmp_hi=1 (too fast) clears trial bit else keeps. stim_en stays 1 until next P_DISCH.
//  Both codes monotonic-increasing (higher code = more gain / higher Fp); bit decided on P_CMP/G_CMP cycle, next bit on following SET.
//  DONE 1 cyc: done=1, cal_ok=1, cal_sat computed, stim_en=0, ref_sel=0, busy drops next cycle.
//  Latency start->done (defaults, no macro): NBIT*(SETTLE_CYC+2) + NBIT*(DISCH_CYC+MEAS_CYC+2) + 1 = 593 cycles.
//  abort (any non-IDLE state): next cycle IDLE, codes restored to saved values, busy=0, stim_en=0, no done pulse, cal_ok=0.
//  abort and start same cycle in IDLE: abort wins. start while busy: no effect. Async rst mid-cal: full reset values, not saved codes.
//  Wait counters sized clog2(max(SETTLE_CYC,DISCH_CYC,MEAS_CYC)+1); parameters of 0 treated as 1 cycle.
// CONFIGURATION
//  DMS_TRIMCAL_MAJ_EN defined: each CMP state lasts 3 cycles, decision = majority of 3 cmp_hi samples; latency +2*2*NBIT (609 default).
//  Undefined: single-sample compare, 1-cycle CMP states as above.
// STRUCTURE
//  cds_rnm_pkg: typedef enum trimcal_state_t (states above), localparam TRIM_NBIT=4.
//  Sub-module dms_sar_reg #(NBIT): init/set_trial/decide(keep)/code/last_bit; instantiated twice (gain, pole).
//  Top holds FSM, wait counter, saved-code registers, majority logic.
// TESTING
//  Comparator model cmp_hi=(gainTrim>=11) in gain phase, (poleTrim>=6) in pole phase -> done at cycle 593, gainTrim=10, poleTrim=5, cal_ok=1, cal_sat=0.
//  cmp_hi tied 0 -> gainTrim=15, poleTrim=15, cal_sat=2'b11; tied 1 -> both 0, cal_sat=2'b11.
//  abort at cycle 300 after start from reset -> next cycle busy=0, gainTrim=8, poleTrim=8, no done, cal_ok=0.
//  rst asserted mid P_STEP -> outputs immediately at reset values; second start completes normally.
//  start pulsed again at cycle 100 -> ignored, single done at 593; abort+start same cycle in IDLE -> stays IDLE.
//  With DMS_TRIMCAL_MAJ_EN: single-cycle cmp_hi glitch inside a CMP window does not flip decision; done at 609.

Source files
------------

// File: rtl/cds_rnm_pkg.sv
// Shared types and constants for the dms 1-pole LPF trim calibration controller.
package cds_rnm_pkg;

  localparam int TRIM_NBIT = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_G_SET,
    ST_G_SETTLE,
    ST_G_CMP,
    ST_P_DISCH,
    ST_P_SET,
    ST_P_STEP,
    ST_P_CMP,
    ST_DONE
  } trimcal_state_t;

  // Zero-length waits still occupy one cycle so the FSM always advances.
  function automatic int at_least_one(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dms_lpf1p_trimcal_if.sv
// Control/observation bundle between the trim calibration controller and its host/filter.
interface dms_lpf1p_trimcal_if #(parameter int NBIT = cds_rnm_pkg::TRIM_NBIT);

  logic            start;
  logic            abort;
  logic            cmp_hi;
  logic [NBIT-1:0] poleTrim;
  logic [NBIT-1:0] gainTrim;
  logic            stim_en;
  logic            ref_sel;
  logic            busy;
  logic            done;
  logic            cal_ok;
  logic [1:0]      cal_sat;

  modport master (
    output start, abort, cmp_hi,
    input  poleTrim, gainTrim, stim_en, ref_sel, busy, done, cal_ok, cal_sat
  );

  modport slave (
    input  start, abort, cmp_hi,
    output poleTrim, gainTrim, stim_en, ref_sel, busy, done, cal_ok, cal_sat
  );

endinterface

// File: rtl/dms_sar_reg.sv
// Successive-approximation code register: trial bit set, keep/clear decision, MSB first.
module dms_sar_reg #(
  parameter int              NBIT    = 4,
  parameter logic [NBIT-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            set_trial,
  input  logic            decide,
  input  logic            keep,
  input  logic            load,
  input  logic [NBIT-1:0] load_val,
  output logic [NBIT-1:0] code,
  output logic [NBIT-1:0] code_next,
  output logic            last_bit
);

  localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;

  always_comb begin
    code_next = code;
    idx_next  = idx;
    if (load) begin
      code_next = load_val;
    end else if (init) begin
      code_next = '0;
      idx_next  = IW'(NBIT - 1);
    end else if (set_trial) begin
      code_next[idx] = 1'b1;
    end else if (decide) begin
      if (!keep) code_next[idx] = 1'b0;
      if (idx != '0) idx_next = idx - IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= RST_VAL;
      idx  <= IW'(NBIT - 1);
    end else begin
      code <= code_next;
      idx  <= idx_next;
    end
  end

  assign last_bit = (idx == '0);

endmodule

// File: rtl/dms_lpf1p_trimcal.sv
// Closed-loop gain/pole trim calibration of the dms 1-pole LPF via SAR on a 1-bit comparator.
// Optional DMS_TRIMCAL_MAJ_EN: 3-cycle compare windows with majority-of-3 decision.
module dms_lpf1p_trimcal
  import cds_rnm_pkg::*;
#(
  parameter int              NBIT       = TRIM_NBIT,
  parameter int              SETTLE_CYC = 64,
  parameter int              MEAS_CYC   = 16,
  parameter int              DISCH_CYC  = 64,
  parameter logic [NBIT-1:0] GAIN_DEF   = NBIT'(8),
  parameter logic [NBIT-1:0] POLE_DEF   = NBIT'(8)
) (
  input logic               clk,
  input logic               rst,
  dms_lpf1p_trimcal_if.slave bus
);

  localparam int SETTLE_N = at_least_one(SETTLE_CYC);
  localparam int MEAS_N   = at_least_one(MEAS_CYC);
  localparam int DISCH_N  = at_least_one(DISCH_CYC);
`ifdef DMS_TRIMCAL_MAJ_EN
  localparam int CMP_N    = 3;
`else
  localparam int CMP_N    = 1;
`endif
  localparam int CW_RAW   = $clog2(max3(SETTLE_N, DISCH_N, MEAS_N) + 1);
  localparam int CW       = (CW_RAW < 2) ? 2 : CW_RAW;

  trimcal_state_t  state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept, restore;
  logic            g_init, g_set, g_dec, p_init, p_set, p_dec;
  logic            disch_entry, done_entry;
  logic            decision, keep;
  logic            g_last, p_last;
  logic [NBIT-1:0] g_code, g_next, p_code, p_next;
  logic [NBIT-1:0] saved_gain, saved_pole;
  logic            stim_en, ref_sel, busy, done, cal_ok;
  logic [1:0]      cal_sat;

`ifdef DMS_TRIMCAL_MAJ_EN
  // The two earlier window samples are shifted in; the third is the live input.
  logic [1:0] smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) smp <= '0;
    else if (state == ST_G_CMP || state == ST_P_CMP) smp <= {smp[0], bus.cmp_hi};
  end

  assign decision = (smp[1] & smp[0]) | (smp[1] & bus.cmp_hi) | (smp[0] & bus.cmp_hi);
`else
  assign decision = bus.cmp_hi;
`endif

  // Comparator high means output too large/fast, so the trial bit is dropped.
  assign keep = !decision;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    accept      = 1'b0;
    restore     = 1'b0;
    g_init      = 1'b0;
    g_set       = 1'b0;
    g_dec       = 1'b0;
    p_init      = 1'b0;
    p_set       = 1'b0;
    p_dec       = 1'b0;
    disch_entry = 1'b0;
    done_entry  = 1'b0;
    if (state != ST_IDLE && bus.abort) begin
      state_n = ST_IDLE;
      restore = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            accept  = 1'b1;
            g_init  = 1'b1;
            state_n = ST_G_SET;
          end
        end
        ST_G_SET: begin
          g_set   = 1'b1;
          cnt_n   = CW'(SETTLE_N - 1);
          state_n = ST_G_SETTLE;
        end
        ST_G_SETTLE: begin
          if (cnt == '0) begin
            cnt_n   = CW'(CMP_N - 1);
            state_n = ST_G_CMP;
          end else cnt_n = cnt - CW'(1);
        end
        ST_G_CMP: begin
          if (cnt == '0) begin
            g_dec = 1'b1;
            if (g_last) begin
              p_init      = 1'b1;
              disch_entry = 1'b1;
              cnt_n       = CW'(DISCH_N - 1);
              state_n     = ST_P_DISCH;
            end else state_n = ST_G_SET;
          end else cnt_n = cnt - CW'(1);
        end
        ST_P_DISCH: begin
          if (cnt == '0) state_n = ST_P_SET;
          else cnt_n = cnt - CW'(1);
        end
        ST_P_SET: begin
          p_set   = 1'b1;
          cnt_n   = CW'(MEAS_N - 1);
          state_n = ST_P_STEP;
        end
        ST_P_STEP: begin
          if (cnt == '0) begin
            cnt_n   = CW'(CMP_N - 1);
            state_n = ST_P_CMP;
          end else cnt_n = cnt - CW'(1);
        end
        ST_P_CMP: begin
          if (cnt == '0) begin
            p_dec = 1'b1;
            if (p_last) begin
              done_entry = 1'b1;
              state_n    = ST_DONE;
            end else begin
              disch_entry = 1'b1;
              cnt_n       = CW'(DISCH_N - 1);
              state_n     = ST_P_DISCH;
            end
          end else cnt_n = cnt - CW'(1);
        end
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  dms_sar_reg #(.NBIT(NBIT), .RST_VAL(GAIN_DEF)) u_gain_sar (
    .clk       (clk),
    .rst       (rst),
    .init      (g_init),
    .set_trial (g_set),
    .decide    (g_dec),
    .keep      (keep),
    .load      (restore),
    .load_val  (saved_gain),
    .code      (g_code),
    .code_next (g_next),
    .last_bit  (g_last)
  );

  dms_sar_reg #(.NBIT(NBIT), .RST_VAL(POLE_DEF)) u_pole_sar (
    .clk       (clk),
    .rst       (rst),
    .init      (p_init),
    .set_trial (p_set),
    .decide    (p_dec),
    .keep      (keep),
    .load      (restore),
    .load_val  (saved_pole),
    .code      (p_code),
    .code_next (p_next),
    .last_bit  (p_last)
  );

  // Saturation flags use the post-decision codes so they are valid with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_en    <= 1'b0;
      ref_sel    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cal_ok     <= 1'b0;
      cal_sat    <= 2'b00;
      saved_gain <= GAIN_DEF;
      saved_pole <= POLE_DEF;
    end else begin
      done <= done_entry;
      if (restore) begin
        stim_en <= 1'b0;
        ref_sel <= 1'b0;
        busy    <= 1'b0;
        cal_ok  <= 1'b0;
      end else if (accept) begin
        saved_gain <= g_code;
        saved_pole <= p_code;
        ref_sel    <= 1'b0;
        busy       <= 1'b1;
        cal_ok     <= 1'b0;
        cal_sat    <= 2'b00;
      end else begin
        if (state == ST_IDLE && bus.abort) cal_ok <= 1'b0;
        if (g_set || p_set) stim_en <= 1'b1;
        if (disch_entry) stim_en <= 1'b0;
        if (p_init) ref_sel <= 1'b1;
        if (state == ST_DONE) busy <= 1'b0;
        if (done_entry) begin
          stim_en <= 1'b0;
          ref_sel <= 1'b0;
          cal_ok  <= 1'b1;
          cal_sat <= {(p_next == '0) || (p_next == '1), (g_next == '0) || (g_next == '1)};
        end
      end
    end
  end

  assign bus.gainTrim = g_code;
  assign bus.poleTrim = p_code;
  assign bus.stim_en  = stim_en;
  assign bus.ref_sel  = ref_sel;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.cal_ok   = cal_ok;
  assign bus.cal_sat  = cal_sat;

endmodule
